// File: rtl/score_link_pkg.sv
// Shared encodings for the score_link UART link: game states, frame headers,
// FSM state types and the score clamp helper.
package score_link_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_WAIT  = 2'd1;
    localparam logic [1:0] STATE_GAME  = 2'd2;
    localparam logic [1:0] STATE_SCORE = 2'd3;

    localparam logic [7:0] HDR_START = 8'hA5;
    localparam logic [7:0] HDR_SCORE = 8'h5C;
    localparam logic [6:0] SCORE_MAX = 7'd99;

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY, TX_CHK} tx_state_t;
    typedef enum logic [1:0] {RX_HDR, RX_PAY_START, RX_PAY_SCORE, RX_CHK} rx_state_t;
    typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;

    function automatic logic [6:0] clamp_score(input logic [6:0] p);
        return (p > SCORE_MAX) ? SCORE_MAX : p;
    endfunction

endpackage

// File: rtl/score_link_uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit start re-check, LSB-first
// sampling and stop-bit check. Emits one-cycle byte_valid / frame_err pulses.
module uart_rx
    import score_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       busy,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_sync, rx_prev;
    bit_state_t    bit_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign busy      = (bit_state != BIT_IDLE);
    assign byte_data = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            bit_state  <= BIT_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (bit_state)
                BIT_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        bit_state <= BIT_START;
                        cnt       <= '0;
                    end
                end
                // A line that is high again at mid-bit was a glitch.
                BIT_START: begin
                    if (cnt == HALF_M1) begin
                        cnt       <= '0;
                        bit_idx   <= '0;
                        bit_state <= rx_sync ? BIT_IDLE : BIT_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) bit_state <= BIT_STOP;
                        else                 bit_idx   <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt       <= '0;
                        bit_state <= BIT_IDLE;
                        if (rx_sync) byte_valid <= 1'b1;
                        else         frame_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/score_link.sv
// UART link to the opponent board: sends START/SCORE frames, receives them back.
// Define SCORE_LINK_CHECKSUM_EN to add a header^payload checksum byte per frame.
module score_link
    import score_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 651,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       rect_clicked_play,
    input  logic [1:0] state,
    input  logic [6:0] my_score,
    output logic       uart_start,
    output logic [6:0] op_score,
    output logic       op_valid,
    output logic       link_err
);

    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TCW = $clog2(TMO_CYCLES + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO_CYCLES - 1);

    // ---------------- transmit ----------------
    tx_state_t      tx_state;
    logic           pend_start, pend_score;
    logic [1:0]     state_q;
    logic [6:0]     score_lat;
    logic [8:0]     tx_shift;
    logic [BCW-1:0] tx_baud;
    logic [3:0]     tx_bit;
    logic [7:0]     tx_pay_q;
`ifdef SCORE_LINK_CHECKSUM_EN
    logic [7:0]     tx_chk_q;
`endif

    logic       bit_end, byte_end, frame_end, can_load;
    logic [7:0] nxt_hdr, nxt_pay;

    always_comb begin
        bit_end  = (tx_state != TX_IDLE) && (tx_baud == BAUD_LAST);
        byte_end = bit_end && (tx_bit == 4'd9);
`ifdef SCORE_LINK_CHECKSUM_EN
        frame_end = byte_end && (tx_state == TX_CHK);
`else
        frame_end = byte_end && (tx_state == TX_PAY);
`endif
        // A pending frame may follow the previous one with no idle gap.
        can_load = ((tx_state == TX_IDLE) || frame_end) && (pend_start || pend_score);
        nxt_hdr  = pend_start ? HDR_START : HDR_SCORE;
        nxt_pay  = pend_start ? 8'h00 : {1'b0, score_lat};
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            tx         <= 1'b1;
            tx_state   <= TX_IDLE;
            pend_start <= 1'b0;
            pend_score <= 1'b0;
            state_q    <= STATE_IDLE;
            score_lat  <= '0;
            tx_shift   <= '1;
            tx_baud    <= '0;
            tx_bit     <= '0;
            tx_pay_q   <= '0;
`ifdef SCORE_LINK_CHECKSUM_EN
            tx_chk_q   <= '0;
`endif
        end else begin
            state_q <= state;
            if (can_load) begin
                tx_state <= TX_HDR;
                tx       <= 1'b0;
                tx_shift <= {1'b1, nxt_hdr};
                tx_baud  <= '0;
                tx_bit   <= '0;
                tx_pay_q <= nxt_pay;
`ifdef SCORE_LINK_CHECKSUM_EN
                tx_chk_q <= nxt_hdr ^ nxt_pay;
`endif
            end else if (byte_end) begin
                tx_baud <= '0;
                tx_bit  <= '0;
                case (tx_state)
                    TX_HDR: begin
                        tx_state <= TX_PAY;
                        tx       <= 1'b0;
                        tx_shift <= {1'b1, tx_pay_q};
                    end
`ifdef SCORE_LINK_CHECKSUM_EN
                    TX_PAY: begin
                        tx_state <= TX_CHK;
                        tx       <= 1'b0;
                        tx_shift <= {1'b1, tx_chk_q};
                    end
`endif
                    default: begin
                        tx_state <= TX_IDLE;
                        tx       <= 1'b1;
                    end
                endcase
            end else if (bit_end) begin
                tx_baud  <= '0;
                tx_bit   <= tx_bit + 1'b1;
                tx       <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
            end else if (tx_state != TX_IDLE) begin
                tx_baud <= tx_baud + 1'b1;
            end

            // Clear the flag being served first so a same-cycle request re-arms it.
            if (can_load) begin
                if (pend_start) pend_start <= 1'b0;
                else            pend_score <= 1'b0;
            end
            if (rect_clicked_play) pend_start <= 1'b1;
            if (state == STATE_SCORE && state_q != STATE_SCORE) begin
                pend_score <= 1'b1;
                score_lat  <= my_score;
            end
        end
    end

    // ---------------- receive ----------------
    logic       rx_busy, rx_byte_valid, rx_frame_err;
    logic [7:0] rx_byte;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (pclk),
        .rst        (rst),
        .rx         (rx),
        .busy       (rx_busy),
        .byte_valid (rx_byte_valid),
        .byte_data  (rx_byte),
        .frame_err  (rx_frame_err)
    );

    rx_state_t      rx_state;
    logic [TCW-1:0] tmo_cnt;
`ifdef SCORE_LINK_CHECKSUM_EN
    logic           rx_is_score;
    logic [7:0]     rx_pay_q;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            rx_state   <= RX_HDR;
            tmo_cnt    <= '0;
            uart_start <= 1'b0;
            op_score   <= '0;
            op_valid   <= 1'b0;
            link_err   <= 1'b0;
`ifdef SCORE_LINK_CHECKSUM_EN
            rx_is_score <= 1'b0;
            rx_pay_q    <= '0;
`endif
        end else begin
            uart_start <= 1'b0;
            link_err   <= 1'b0;
            if (rx_frame_err) begin
                link_err <= 1'b1;
                rx_state <= RX_HDR;
                tmo_cnt  <= '0;
            end else if (rx_byte_valid) begin
                tmo_cnt <= '0;
                case (rx_state)
                    RX_HDR: begin
                        if (rx_byte == HDR_START)      rx_state <= RX_PAY_START;
                        else if (rx_byte == HDR_SCORE) rx_state <= RX_PAY_SCORE;
                    end
`ifdef SCORE_LINK_CHECKSUM_EN
                    RX_PAY_START, RX_PAY_SCORE: begin
                        rx_is_score <= (rx_state == RX_PAY_SCORE);
                        rx_pay_q    <= rx_byte;
                        rx_state    <= RX_CHK;
                    end
                    default: begin
                        rx_state <= RX_HDR;
                        if (rx_byte == ((rx_is_score ? HDR_SCORE : HDR_START) ^ rx_pay_q)) begin
                            if (rx_is_score) begin
                                op_score <= clamp_score(rx_pay_q[6:0]);
                                op_valid <= 1'b1;
                            end else begin
                                uart_start <= 1'b1;
                                op_valid   <= 1'b0;
                            end
                        end else begin
                            link_err <= 1'b1;
                        end
                    end
`else
                    RX_PAY_START: begin
                        uart_start <= 1'b1;
                        op_valid   <= 1'b0;
                        rx_state   <= RX_HDR;
                    end
                    default: begin
                        op_score <= clamp_score(rx_byte[6:0]);
                        op_valid <= 1'b1;
                        rx_state <= RX_HDR;
                    end
`endif
                endcase
            end else if (rx_state != RX_HDR && !rx_busy) begin
                // The wait only runs while no byte is arriving.
                if (tmo_cnt == TMO_LAST) begin
                    link_err <= 1'b1;
                    rx_state <= RX_HDR;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_link.sv
// Bench for score_link at 16 clocks per bit: directed TX/RX frames, error cases
// and randomized RX frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_score_link;
    import score_link_pkg::*;

    localparam int CPB     = 16;
    localparam int BYTE_T  = 10 * CPB;
`ifdef SCORE_LINK_CHECKSUM_EN
    localparam int FRAME_B = 3;
`else
    localparam int FRAME_B = 2;
`endif

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rect_clicked_play = 1'b0;
    logic [1:0] state = STATE_IDLE;
    logic [6:0] my_score = '0;
    logic       tx, uart_start, op_valid, link_err;
    logic [6:0] op_score;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // clock / reset block
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    score_link #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(40)) dut (
        .pclk              (pclk),
        .rst               (rst),
        .rx                (rx),
        .tx                (tx),
        .rect_clicked_play (rect_clicked_play),
        .state             (state),
        .my_score          (my_score),
        .uart_start        (uart_start),
        .op_score          (op_score),
        .op_valid          (op_valid),
        .link_err          (link_err)
    );

    // pulse counters
    int   start_cnt = 0, err_cnt = 0, wide_cnt = 0;
    logic start_d = 1'b0, err_d = 1'b0;
    always @(negedge pclk) begin
        if (uart_start === 1'b1) start_cnt <= start_cnt + 1;
        if (link_err === 1'b1)   err_cnt   <= err_cnt + 1;
        if ((uart_start && start_d) || (link_err && err_d)) wide_cnt <= wide_cnt + 1;
        start_d <= uart_start;
        err_d   <= link_err;
    end

    // tx decoder: byte value, start-bit cycle and stop bit of every byte seen
    logic [7:0] got_b[$];
    int         got_t[$];
    logic       got_s[$];
    logic [7:0] exp_q[$];

    initial begin
        logic [7:0] b;
        int         t;
        forever begin
            @(negedge pclk);
            if (!rst && tx === 1'b0) begin
                t = cyc;
                repeat (CPB / 2) @(negedge pclk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge pclk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge pclk);
                got_s.push_back(tx);
                got_b.push_back(b);
                got_t.push_back(t);
                repeat (CPB / 2 - 1) @(negedge pclk);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tx();
        got_b.delete();
        got_t.delete();
        got_s.delete();
        exp_q.delete();
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [7:0] pay);
        exp_q.push_back(hdr);
        exp_q.push_back(pay);
`ifdef SCORE_LINK_CHECKSUM_EN
        exp_q.push_back(hdr ^ pay);
`endif
    endtask

    task automatic check_tx(input string tag, input int t0);
        check({tag, "_count"}, got_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_b[i], exp_q[i]);
            check($sformatf("%s_stop%0d", tag, i), got_s[i], 1);
            check($sformatf("%s_time%0d", tag, i), got_t[i] - t0, 2 + BYTE_T * i);
        end
        clear_tx();
    endtask

    // driver tasks (called at a negedge)
    task automatic pulse_play(output int t0);
        rect_clicked_play = 1'b1;
        t0 = cyc;
        @(negedge pclk);
        rect_clicked_play = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge pclk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge pclk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge pclk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] pay);
        send_byte(hdr, 1'b1);
        send_byte(pay, 1'b1);
`ifdef SCORE_LINK_CHECKSUM_EN
        send_byte(hdr ^ pay, 1'b1);
`endif
    endtask

    initial begin
        int         t0, bad, s0, e0;
        int         exp_score, exp_valid, exp_starts;
        logic [7:0] pay, junk;
        int         kind;

        // reset
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        check("rst_tx", tx, 1);
        check("rst_op_score", op_score, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_uart_start", uart_start, 0);
        check("rst_link_err", link_err, 0);
        rst = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge pclk);
            if (tx !== 1'b1 || uart_start !== 1'b0 || link_err !== 1'b0) bad++;
        end
        check("idle_1000", bad, 0);

        // PLAY click -> START frame
        pulse_play(t0);
        push_frame(HDR_START, 8'h00);
        repeat (FRAME_B * BYTE_T + 40) @(negedge pclk);
        check_tx("tx_start", t0);
        check("tx_idle_after", tx, 1);

        // reset in the middle of a byte abandons it
        pulse_play(t0);
        repeat (50) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        check("rst_mid_tx", tx, 1);
        @(negedge pclk);
        rst = 1'b0;
        repeat (200) @(negedge pclk);
        clear_tx();
        repeat (300) @(negedge pclk);
        check("rst_mid_no_resume", got_b.size(), 0);

        // PLAY and entry to SCORE on the same cycle: START then SCORE, back-to-back
        state = STATE_GAME;
        repeat (3) @(negedge pclk);
        state = STATE_SCORE;
        my_score = 7'd17;
        pulse_play(t0);
        my_score = 7'd55;
        push_frame(HDR_START, 8'h00);
        push_frame(HDR_SCORE, 8'h11);
        repeat (2 * FRAME_B * BYTE_T + 40) @(negedge pclk);
        check_tx("tx_both", t0);
        state = STATE_GAME;

        // RX score, then START
        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(HDR_SCORE, 8'h2A);
        check("rx_score42", op_score, 42);
        check("rx_valid42", op_valid, 1);
        send_frame(HDR_START, 8'h00);
        repeat (2) @(negedge pclk);
        check("rx_start_pulse", start_cnt - s0, 1);
        check("rx_start_clears_valid", op_valid, 0);
        check("rx_start_keeps_score", op_score, 42);

        // clamp
        send_frame(HDR_SCORE, 8'h7F);
        check("rx_clamp", op_score, 99);
        check("rx_no_err", err_cnt - e0, 0);

        // bad stop bit on a START header
        s0 = start_cnt;
        e0 = err_cnt;
        send_byte(HDR_START, 1'b0);
        repeat (40) @(negedge pclk);
        check("stop_err_pulse", err_cnt - e0, 1);
        check("stop_err_no_start", start_cnt - s0, 0);

        // timeout between header and payload, then recovery
        e0 = err_cnt;
        send_byte(HDR_SCORE, 1'b1);
        repeat (700) @(negedge pclk);
        check("timeout_err", err_cnt - e0, 1);
        send_frame(HDR_SCORE, 8'h05);
        check("after_timeout_score", op_score, 5);
        check("after_timeout_valid", op_valid, 1);
        check("after_timeout_no_err", err_cnt - e0, 1);

        // unknown header byte is ignored
        send_byte(8'h33, 1'b1);
        repeat (10) @(negedge pclk);
        send_frame(HDR_SCORE, 8'h0A);
        check("junk_then_score", op_score, 10);
        check("junk_no_err", err_cnt - e0, 1);

`ifdef SCORE_LINK_CHECKSUM_EN
        e0 = err_cnt;
        send_byte(HDR_SCORE, 1'b1);
        send_byte(8'h0C, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (2) @(negedge pclk);
        check("chk_bad_err", err_cnt - e0, 1);
        check("chk_bad_score_kept", op_score, 10);
`endif

        // randomized RX frames while a START frame is being transmitted
        exp_score  = op_score;
        exp_valid  = op_valid;
        exp_starts = start_cnt;
        e0 = err_cnt;
        pulse_play(t0);
        push_frame(HDR_START, 8'h00);
        for (int n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 2);
            pay  = 8'($urandom_range(0, 127));
            if (kind == 0) begin
                send_frame(HDR_START, pay);
                exp_starts++;
                exp_valid = 0;
            end else if (kind == 1) begin
                send_frame(HDR_SCORE, pay);
                exp_score = (pay > 99) ? 99 : pay;
                exp_valid = 1;
            end else begin
                junk = 8'($urandom_range(0, 255));
                if (junk == HDR_START || junk == HDR_SCORE) junk = 8'h3C;
                send_byte(junk, 1'b1);
            end
            repeat (2) @(negedge pclk);
            check($sformatf("rnd%0d_score", n), op_score, exp_score);
            check($sformatf("rnd%0d_valid", n), op_valid, exp_valid);
            check($sformatf("rnd%0d_starts", n), start_cnt, exp_starts);
            repeat ($urandom_range(0, 20)) @(negedge pclk);
        end
        check("rnd_no_err", err_cnt - e0, 0);
        check_tx("tx_duplex", t0);
        check("pulse_width", wide_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/score_link.md
Name: score_link

Overview:
- UART link between the two game boards.
- Carries the local PLAY click and the local final score to the opponent.
- Returns the opponent's start request and score.
- Sits beside the state machine. It consumes rect_clicked_play, state and my_score, and produces uart_start and op_score for the state machine, score2ascii_converter and compare_score.
- Serial framing is 8N1, LSB first, idle high.

Parameters:
- CLKS_PER_BIT, 651, pclk cycles per UART bit (75 MHz / 115200).
- TIMEOUT_BITS, 40, maximum bit-times allowed between a header byte and its payload start bit.

Ports:
- pclk  in  1  pixel clock, 75 MHz
- rst  in  1  synchronous reset, active-high
- rx  in  1  serial input from opponent (asynchronous)
- tx  out  1  serial output to opponent
- rect_clicked_play  in  1  one-cycle pulse: local PLAY button clicked
- state  in  2  game state from the state machine
- my_score  in  7  local score, 0..99
- uart_start  out  1  one-cycle pulse: opponent START frame received
- op_score  out  7  last received opponent score
- op_valid  out  1  op_score holds a score received since the last START
- link_err  out  1  one-cycle pulse on framing error, timeout or checksum error

Behaviour:
- Clock and reset: single clock domain on pclk. Reset is synchronous and active-high on rst.
- Reset values: tx=1, uart_start=0, op_score=0, op_valid=0, link_err=0. All FSMs, pending flags and counters are cleared. Reset asserted mid-byte forces tx=1 on the next edge; the partial byte is abandoned.
- Frames are 2 bytes:
  - START = 8'hA5, 8'h00
  - SCORE = 8'h5C, {1'b0, my_score}
- TX pending flags:
  - pend_start is set by rect_clicked_play.
  - pend_score is set on the cycle state changes from any value to STATE_SCORE. my_score is latched on that same cycle.
  - A new request while the same flag is already set merges; it does not queue twice.
  - If both flags are set, START is sent first.
- TX FSM:
  - TX_IDLE -> TX_HDR -> TX_PAY -> TX_IDLE.
  - Each byte is 10 bits: start(0), 8 data bits LSB first, stop(1). Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bytes within a frame are sent back-to-back with no gap.
  - tx falls to the start bit 2 cycles after the request pulse when TX_IDLE.
- RX synchronisation and byte capture:
  - rx passes through a 2-flop synchronizer.
  - A start bit is detected on a falling edge and re-checked at CLKS_PER_BIT/2. If low, it is a valid start; otherwise it is a glitch and is ignored.
  - Data bits are sampled every CLKS_PER_BIT after the start-bit re-check.
  - If the stop bit samples 0: pulse link_err, discard the byte, and return the frame FSM to RX_HDR.
- RX frame FSM:
  - RX_HDR: byte A5 -> RX_PAY_START; byte 5C -> RX_PAY_SCORE; any other byte is ignored silently.
  - RX_PAY_START: any payload is accepted. Pulse uart_start 1 cycle after the stop-bit sample, clear op_valid, return to RX_HDR.
  - RX_PAY_SCORE: set op_score = payload[6:0] and op_valid=1 one cycle after the stop-bit sample. A payload above 99 is clamped to 99. Return to RX_HDR.
  - Timeout: in any RX_PAY state, if no start bit arrives within TIMEOUT_BITS*CLKS_PER_BIT cycles, pulse link_err and return to RX_HDR.
- Concurrency: TX and RX are fully independent (full duplex). Simultaneous transmit and receive activity has no effect on either.

Optional Feature:
- Macro: SCORE_LINK_CHECKSUM_EN.
- Defined:
  - Every frame gains a third byte: checksum = header XOR payload.
  - TX sends it directly after the payload.
  - RX adds an RX_CHK state. uart_start and the op_score update take effect only after the checksum matches, one cycle after the checksum stop-bit sample.
  - On mismatch: pulse link_err and discard the frame.
- Undefined: 2-byte frames exactly as described under Behaviour.

Decomposition:
- Package score_link_pkg:
  - state encodings STATE_IDLE=2'd0, STATE_WAIT=2'd1, STATE_GAME=2'd2, STATE_SCORE=2'd3 (shared with the state machine)
  - header constants HDR_START=8'hA5, HDR_SCORE=8'h5C
  - TX/RX FSM state typedefs
- Sub-module uart_rx: synchronizer, start-bit detect, bit sampling and framing check. Outputs a byte_valid pulse, byte data and a frame_err pulse.
- The TX serializer and the framing FSMs stay in score_link.

Test Plan:
- All scenarios use CLKS_PER_BIT=16.
- Reset with rst=1 for 3 cycles -> tx=1, op_score=0, op_valid=0, no pulses. After release tx stays 1 for 1000 cycles.
- rect_clicked_play pulse -> tx carries bytes A5, 00; each bit is 16 cycles; the first start bit appears 2 cycles after the pulse; total 320 cycles.
- Drive rx with 5C, 2A -> op_score=42 and op_valid=1, one cycle after the second stop-bit sample. Then drive A5, 00 -> one-cycle uart_start pulse and op_valid=0.
- Edge cases:
  - rect_clicked_play and state change 2->3 (my_score=17) on the same cycle -> frame A5 00 then 5C 11, back-to-back.
  - Drive rx with 5C, 7F -> op_score clamps to 99.
- Error cases:
  - Byte A5 with stop bit 0 -> link_err pulse, no uart_start.
  - 5C followed by 700 idle cycles -> link_err pulse on timeout. A following 5C, 05 is still accepted: op_score=5.
- With SCORE_LINK_CHECKSUM_EN defined:
  - rx 5C, 0A, 56 -> op_score=10.
  - rx 5C, 0A, 00 -> link_err pulse, op_score unchanged.
